// File: rtl/pong_pkg.sv
// pong_pkg: shared types and screen constants for the pong demo on the
// 480x272 AT043TN25 panel.
//   SCREEN_W / SCREEN_H : visible panel size in pixels
//   dir_t               : decoded button direction
//   hold_state_t        : button hold / auto-repeat state machine states
package pong_pkg;

    localparam int SCREEN_W = 480;
    localparam int SCREEN_H = 272;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_t;

endpackage

// File: rtl/key_repeat.sv
// key_repeat: synchronises the raw up/down buttons, decodes a direction and
// runs the hold / auto-repeat state machine. A fresh press latches a pending
// step. Holding the button then produces further steps after REPEAT_DELAY
// frame ticks, and every REPEAT_RATE ticks after that.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_up, i_down    raw asynchronous buttons, active-high
//   i_frame_tick    one-cycle pulse per frame
//   i_mode_ai       AI mode: state machine held in IDLE, pending cleared
//   o_step_req      take one step on this (tick) cycle
//   o_step_dir      direction of that step
module key_repeat
    import pong_pkg::*;
#(
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_up,
    input  logic i_down,
    input  logic i_frame_tick,
    input  logic i_mode_ai,
    output logic o_step_req,
    output dir_t o_step_dir
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic        up_meta_r, up_sync_r, dn_meta_r, dn_sync_r;
    dir_t        dir_s;
    hold_state_t state_r, state_nxt_s;
    dir_t        hold_dir_r, hold_dir_nxt_s;
    dir_t        pend_dir_r, pend_dir_nxt_s;
    logic        pending_r, pending_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic        fire_s;

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            up_meta_r <= 1'b0;
            up_sync_r <= 1'b0;
            dn_meta_r <= 1'b0;
            dn_sync_r <= 1'b0;
        end else begin
            up_meta_r <= i_up;
            up_sync_r <= up_meta_r;
            dn_meta_r <= i_down;
            dn_sync_r <= dn_meta_r;
        end
    end

    // Direction decode: both buttons together cancel out.
    always_comb begin
        dir_s = DIR_NONE;
        if (up_sync_r && !dn_sync_r) begin
            dir_s = DIR_UP;
        end else if (dn_sync_r && !up_sync_r) begin
            dir_s = DIR_DOWN;
        end else begin
            dir_s = DIR_NONE;
        end
    end

    // Hold state machine registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            hold_dir_r <= DIR_NONE;
            pend_dir_r <= DIR_NONE;
            pending_r  <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            hold_dir_r <= hold_dir_nxt_s;
            pend_dir_r <= pend_dir_nxt_s;
            pending_r  <= pending_nxt_s;
            cnt_r      <= cnt_nxt_s;
        end
    end

    // Next state: a fresh press wins over the tick that clears pending;
    // any change of the held direction drops back to IDLE.
    always_comb begin
        state_nxt_s    = state_r;
        hold_dir_nxt_s = hold_dir_r;
        pend_dir_nxt_s = pend_dir_r;
        pending_nxt_s  = pending_r;
        cnt_nxt_s      = cnt_r;
        fire_s         = 1'b0;
        if (i_mode_ai) begin
            state_nxt_s    = IDLE;
            hold_dir_nxt_s = DIR_NONE;
            pending_nxt_s  = 1'b0;
            cnt_nxt_s      = {CNT_W{1'b0}};
        end else begin
            if (i_frame_tick) begin
                pending_nxt_s = 1'b0;
            end else begin
                pending_nxt_s = pending_r;
            end
            case (state_r)
                IDLE: begin
                    if (dir_s != DIR_NONE) begin
                        pending_nxt_s  = 1'b1;
                        pend_dir_nxt_s = dir_s;
                        hold_dir_nxt_s = dir_s;
                        cnt_nxt_s      = CNT_W'(REPEAT_DELAY);
                        state_nxt_s    = HOLD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HOLD, REPEAT: begin
                    if (dir_s != hold_dir_r) begin
                        state_nxt_s = IDLE;
                    end else if (i_frame_tick) begin
                        // Counter reaching zero on this tick fires the step now.
                        if (cnt_r == CNT_W'(1)) begin
                            fire_s      = 1'b1;
                            cnt_nxt_s   = CNT_W'(REPEAT_RATE);
                            state_nxt_s = REPEAT;
                        end else begin
                            cnt_nxt_s = cnt_r - CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // A pending press and a repeat step on the same tick merge into one.
    assign o_step_req = i_frame_tick & ~i_mode_ai & (pending_r | fire_s);
    assign o_step_dir = pending_r ? pend_dir_r : hold_dir_r;

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: pong paddle controller. Moves the paddle vertically from the
// buttons (with auto-repeat) or follows the ball in AI mode, updating the
// position only on frame ticks and clamping to the screen. Also produces a
// registered "pixel inside paddle" flag for the video mixer.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_up, i_down     raw asynchronous buttons, active-high
//   i_frame_tick     one-cycle pulse per frame (vblank start)
//   i_mode_ai        1 = follow i_ball_y, buttons ignored
//   i_ball_y         ball centre row
//   i_col, i_row     current pixel coordinate
//   o_color          pixel inside paddle, one cycle after i_col/i_row
//   o_y              paddle top row
//   o_h              paddle height (constant)
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int X_W          = 9,
    parameter int Y_W          = 9,
    parameter int H_W          = 7,
    parameter int START_X      = 0,
    parameter int START_Y      = 0,
    parameter int WIDTH        = 5,
    parameter int HEIGHT       = 50,
    parameter int Y_MAX        = SCREEN_H,
    parameter int STEP         = 10,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 4,
    parameter int AI_STEP      = 2,
    parameter int AI_DEADBAND  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_up,
    input  logic           i_down,
    input  logic           i_frame_tick,
    input  logic           i_mode_ai,
    input  logic [Y_W-1:0] i_ball_y,
    input  logic [X_W-1:0] i_col,
    input  logic [Y_W-1:0] i_row,
    output logic           o_color,
    output logic [Y_W-1:0] o_y,
    output logic [H_W-1:0] o_h
);

    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    if (HEIGHT > Y_MAX) begin : g_err_height
        $error("paddle_ctrl: HEIGHT exceeds Y_MAX");
    end
    if (START_Y + HEIGHT > Y_MAX) begin : g_err_start
        $error("paddle_ctrl: START_Y + HEIGHT exceeds Y_MAX");
    end
    if (REPEAT_DELAY == 0) begin : g_err_delay
        $error("paddle_ctrl: REPEAT_DELAY must be non-zero");
    end
    if (REPEAT_RATE == 0) begin : g_err_rate
        $error("paddle_ctrl: REPEAT_RATE must be non-zero");
    end

    // One saturating step, evaluated one bit wider so the sums cannot wrap.
    function automatic logic [Y_W-1:0] step_pos(input logic [Y_W-1:0] y,
                                                input logic go_up,
                                                input logic [Y_W:0] amt);
        logic [Y_W:0] yw;
        logic [Y_W:0] r;
        yw = {1'b0, y};
        if (go_up) begin
            r = (yw >= amt) ? (yw - amt) : {YW1{1'b0}};
        end else begin
            r = ((yw + YW1'(HEIGHT) + amt) <= YW1'(Y_MAX)) ? (yw + amt)
                                                           : YW1'(Y_MAX - HEIGHT);
        end
        return Y_W'(r);
    endfunction

    logic           step_req_s;
    dir_t           step_dir_s;
    logic [Y_W-1:0] y_r, y_nxt_s;
    logic [Y_W:0]   centre_s, centre_hi_s, ball_w_s, ball_lo_s;
    logic [X_W:0]   col_off_s;
    logic [Y_W:0]   row_off_s;
    logic           inside_s;
    logic           color_r;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_key_repeat (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_up         (i_up),
        .i_down       (i_down),
        .i_frame_tick (i_frame_tick),
        .i_mode_ai    (i_mode_ai),
        .o_step_req   (step_req_s),
        .o_step_dir   (step_dir_s)
    );

    assign centre_s    = {1'b0, y_r} + YW1'(HEIGHT / 2);
    assign centre_hi_s = centre_s + YW1'(AI_DEADBAND);
    assign ball_w_s    = {1'b0, i_ball_y};
    assign ball_lo_s   = ball_w_s + YW1'(AI_DEADBAND);

    // Next paddle position: changes only on a frame tick.
    always_comb begin
        y_nxt_s = y_r;
        if (i_frame_tick) begin
            if (i_mode_ai) begin
                if (ball_lo_s < centre_s) begin
                    y_nxt_s = step_pos(y_r, 1'b1, YW1'(AI_STEP));
                end else if (ball_w_s > centre_hi_s) begin
                    y_nxt_s = step_pos(y_r, 1'b0, YW1'(AI_STEP));
                end else begin
                    y_nxt_s = y_r;
                end
            end else if (step_req_s && (step_dir_s != DIR_NONE)) begin
                y_nxt_s = step_pos(y_r, step_dir_s == DIR_UP, YW1'(STEP));
            end else begin
                y_nxt_s = y_r;
            end
        end else begin
            y_nxt_s = y_r;
        end
    end

    // Unsigned offset trick: a coordinate below the lower bound wraps to a
    // value of at least 2**width, which can never be below WIDTH/HEIGHT, so
    // a single compare covers both the lower and the upper bound.
    assign col_off_s = {1'b0, i_col} - XW1'(START_X);
    assign row_off_s = {1'b0, i_row} - {1'b0, y_r};
    assign inside_s  = (col_off_s < XW1'(WIDTH)) && (row_off_s < YW1'(HEIGHT));

    // Paddle position and pixel-hit registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y_r     <= Y_W'(START_Y);
            color_r <= 1'b0;
        end else begin
            y_r     <= y_nxt_s;
            color_r <= inside_s;
        end
    end

    assign o_y     = y_r;
    assign o_color = color_r;
    assign o_h     = H_W'(HEIGHT);

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised paddle controller for the pong demo on the 480x272 AT043TN25 panel. It handles button-driven or AI-driven vertical movement with auto-repeat, frame-synchronous position updates and edge clamping. It also generates a registered pixel-hit flag for the video mixer, and sits between the board buttons/ball tracker and the LCD timing/colour path.

Parameters:
X_W, 9, width of column coordinate
Y_W, 9, width of row coordinate / paddle y
H_W, 7, width of o_h
START_X, 0, paddle left column (fixed)
START_Y, 0, y after reset
WIDTH, 5, paddle width in pixels
HEIGHT, 50, paddle height in pixels
Y_MAX, 272, screen height; paddle bottom never exceeds it
STEP, 10, pixels per button step
REPEAT_DELAY, 20, frame ticks held before auto-repeat starts
REPEAT_RATE, 4, frame ticks between repeat steps
AI_STEP, 2, pixels per tick in AI mode
AI_DEADBAND, 4, AI dead zone around paddle centre

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_up  in  1  raw up button, asynchronous, active-high
i_down  in  1  raw down button, asynchronous, active-high
i_frame_tick  in  1  one-cycle pulse per frame (vblank start)
i_mode_ai  in  1  1 = AI follows i_ball_y; buttons ignored
i_ball_y  in  Y_W  ball centre row
i_col  in  X_W  current pixel column
i_row  in  Y_W  current pixel row
o_color  out  1  pixel inside paddle, registered
o_y  out  Y_W  paddle top row
o_h  out  H_W  constant HEIGHT

Behaviour:
- Reset (async, i_rst_n=0): o_y=START_Y, o_color=0, FSM=IDLE, pending=0, repeat counter=0, synchroniser flops=0. Reset mid-move discards pending step.
- i_up/i_down pass through 2-flop synchronisers. dir = UP if up&~down, DOWN if down&~up, else NONE (both pressed = NONE).
- Hold FSM (button mode only):
  - IDLE: dir!=NONE -> set pending=1 with pend_dir=dir, cnt=REPEAT_DELAY, go HOLD.
  - HOLD: per tick cnt-1; when cnt hits 0 -> step on that tick, cnt=REPEAT_RATE, go REPEAT.
  - REPEAT: per tick cnt-1; at 0 -> step, reload REPEAT_RATE.
  - Any state: dir changes (incl. NONE) -> IDLE next cycle; pending already latched is kept.
- Position updates only on i_frame_tick cycles; o_y is stable between ticks. Pending step and repeat step on the same tick = one step. pending cleared on tick.
- Step arithmetic in Y_W+1 bits, saturating:
  - UP: y>=STEP ? y-STEP : 0.
  - DOWN: y+HEIGHT+STEP<=Y_MAX ? y+STEP : Y_MAX-HEIGHT.
- AI mode: FSM forced to IDLE, pending cleared, buttons ignored. On each tick, centre = y+HEIGHT/2:
  - i_ball_y+AI_DEADBAND < centre -> UP by AI_STEP.
  - i_ball_y > centre+AI_DEADBAND -> DOWN by AI_STEP.
  - else hold. Same clamping as button steps.
- Mode toggle takes effect next cycle; no step is lost or duplicated beyond the pending clear.
- o_color latency is 1 cycle: registered (i_col>=START_X && i_col<START_X+WIDTH && i_row>=o_y && i_row<o_y+HEIGHT), compares done in widened width.
- o_h = HEIGHT, combinational constant.
- Elaboration error if HEIGHT>Y_MAX, START_Y+HEIGHT>Y_MAX, REPEAT_DELAY=0 or REPEAT_RATE=0.

Decomposition:
- Package pong_pkg: SCREEN_W=480, SCREEN_H=272, dir_t enum {DIR_NONE, DIR_UP, DIR_DOWN}, hold FSM state enum {IDLE, HOLD, REPEAT}.
- Sub-module key_repeat: synchroniser + dir decode + hold FSM + counter, outputs step request and direction. paddle_ctrl owns position, clamp, AI and pixel compare.

Test Plan:
1. Reset with START_Y=110, press up for 2 cycles, then tick -> o_y=100; o_color=0 during reset; no change before tick.
2. START_Y=5, up then tick -> o_y=0. START_Y=215, down then tick -> o_y=222 (clamped, 222+50=272).
3. Hold down across ticks 1..30 with START_Y=110, DELAY=20, RATE=4 -> steps at ticks 1, 20, 24, 28; final o_y=150.
4. Up and down held together for 10 ticks -> o_y unchanged. Release and assert reset mid-HOLD -> o_y=START_Y, FSM IDLE.
5. AI mode, y=110, i_ball_y=200 -> o_y 112, 114, ... per tick. i_ball_y=137 (within deadband of centre 135+) -> no move. Buttons toggling -> ignored.
6. START_X=10, o_y=100: row 100..149 with col 10..14 -> o_color=1 one cycle later; col 15, row 99 or row 150 -> 0.
